charlieplex_scanner: RTL and testbench
======================================

Name: charlieplex_scanner

Overview:
Drives the 7-pin charlieplexed LED matrix (42 LEDs) through the tristate pad cells at the board top. It produces charlieplex_oe/charlieplex_o from a double-buffered per-LED brightness store. The store is written by the core over a simple valid/ready port. The block scans one anode pin at a time, applies BITS-bit PWM per LED, and inserts a blanking gap between rows to suppress ghosting.

Parameters:
PINS, 7, number of charlieplex pins; LEDS = PINS*(PINS-1); AW = $clog2(LEDS)
BITS, 4, brightness bits per LED
STEP_CYCLES, 64, clk cycles per PWM step
DEAD_CYCLES, 16, clk cycles of all-pins-hi-Z blanking before each row

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request to back buffer
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  AW  LED index
wr_data  in  BITS  brightness
wr_commit  in  1  request back->front copy at next frame end (single-cycle pulse)
commit_pending  out  1  commit latched, not yet applied
frame_sync  out  1  one-cycle pulse on last cycle of row PINS-1
charlieplex_oe  out  PINS  pad output enables
charlieplex_o  out  PINS  pad output data

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). On assertion, all of the following clear immediately, including mid-scan: oe=0, o=0, frame_sync=0, commit_pending=0, wr_ready=1, both buffers =0, state=DEAD, row=0, pwm=0, prescaler=0.
- LED index mapping: idx = row*(PINS-1) + c', where cathode c != row and c' = c if c<row, else c-1. Examples: idx 0 = (row 0, pin 1); idx 6 = (row 1, pin 0); idx 41 = (row 6, pin 5).
- State DEAD: lasts DEAD_CYCLES cycles; oe=0, o=0. Then go to DRIVE.
- State DRIVE: lasts 2^BITS * STEP_CYCLES cycles. pwm increments every STEP_CYCLES cycles.
  - Anode pin: oe[row]=1, o[row]=1.
  - Each cathode c != row: o[c]=0, oe[c] = (front[idx] > pwm).
  - Brightness 0 is never lit; brightness 2^BITS-1 is lit for 2^BITS-1 of 2^BITS steps.
- At the end of DRIVE: row increments and wraps from PINS-1 to 0; state returns to DEAD.
- Row period = DEAD_CYCLES + 2^BITS*STEP_CYCLES. Frame = PINS row periods.
- Outputs are registered and glitch-free. At most one pin has o=1 at any time.
- Write port:
  - A write is accepted when wr_valid && wr_ready; back[wr_addr] <= wr_data.
  - wr_addr >= LEDS is accepted and discarded.
  - wr_ready = !commit_pending.
- Commit:
  - wr_commit sets commit_pending.
  - At the next frame_sync cycle where commit_pending was already set, front <= back (back is unchanged), commit_pending clears, and wr_ready returns to 1 on the following cycle.
  - wr_commit arriving on a frame_sync cycle is latched for the following frame.
  - wr_valid and wr_commit in the same cycle: the write is accepted and included in that commit.
  - wr_commit while already pending: no effect.
- Front-buffer contents never change mid-frame, so there is no tearing.

Decomposition:
- Shared package charlieplex_pkg holds:
  - typedef brightness_t (logic[BITS-1:0]);
  - scan state enum {DEAD, DRIVE};
  - function led_index(row, pin) implementing the mapping above.
- One sub-module is natural: charlieplex_pwm_timer. It owns the prescaler, pwm, row and state counters, and emits row, pwm, drive_en and frame_sync. The top level holds the buffers, write/commit logic and the output decode.

Test Plan:
(Bench parameters: PINS=7, BITS=4, STEP_CYCLES=2, DEAD_CYCLES=3; row period 35 cycles, frame 245 cycles.)
- Reset release, no writes -> oe=0 for 3 cycles, then oe=7'b0000001 and o=7'b0000001 for 32 cycles, then 3 blank cycles, then oe=7'b0000010. frame_sync pulses at cycle 244 and every 245 cycles after.
- Write idx0=15, then commit -> after the next frame_sync, in row 0 oe=7'b0000011 for 30 cycles, then 7'b0000001 for 2 cycles. Before that frame_sync, no change.
- Write idx41=8 and idx6=1, then commit -> row 6: oe[5]=1 for 16 cycles of 32. Row 1: oe[0]=1 for 2 cycles. No other cathode enabled.
- wr_commit -> wr_ready=0 until frame_sync, then 1 the cycle after. A wr_valid held during the pending window is accepted only after ready returns and appears in the front buffer only after the next commit.
- wr_addr=42, data=15 -> accepted, no LED ever lit. wr_commit on a frame_sync cycle -> copy happens one frame later.
- Assert rst_n=0 mid-DRIVE with LEDs lit -> oe and o become 0 in the same cycle (asynchronously). After release, the scan restarts at row 0 DEAD with all buffers cleared.

Source files
------------

// File: rtl/charlieplex_pkg.sv
// Shared types and the LED index mapping for the charlieplex scanner.
// The pin count and brightness width are fixed here for the whole slice.
package charlieplex_pkg;

    localparam int PINS = 7;
    localparam int BITS = 4;
    localparam int LEDS = PINS * (PINS - 1);
    localparam int AW   = $clog2(LEDS);
    localparam int RW   = $clog2(PINS);

    typedef logic [BITS-1:0] brightness_t;
    typedef logic [AW-1:0]   led_addr_t;
    typedef logic [RW-1:0]   row_t;

    typedef enum logic {DEAD, DRIVE} scan_state_e;

    // Cathodes above the anode shift down one slot to skip the anode itself.
    function automatic led_addr_t led_index(row_t row, row_t pin);
        int r;
        int p;
        r = int'(row);
        p = int'(pin);
        return led_addr_t'(r * (PINS - 1) + ((p < r) ? p : p - 1));
    endfunction

endpackage

// File: rtl/charlieplex_if.sv
// Core-side write/commit port of the charlieplex scanner.
// master = core, slave = scanner.
interface charlieplex_if;
    import charlieplex_pkg::*;

    logic        wr_valid;
    logic        wr_ready;
    led_addr_t   wr_addr;
    brightness_t wr_data;
    logic        wr_commit;
    logic        commit_pending;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_commit,
        input  wr_ready, commit_pending
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_commit,
        output wr_ready, commit_pending
    );

endinterface

// File: rtl/charlieplex_pwm_timer.sv
// Row/PWM scan sequencer: DEAD blanking then DRIVE per row.
// Exposes next-state values so the pad outputs can be registered in phase.
module charlieplex_pwm_timer
    import charlieplex_pkg::*;
#(
    parameter int STEP_CYCLES = 64,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output row_t        row_d_o,
    output brightness_t pwm_d_o,
    output logic        drive_d_o,
    output logic        frame_sync_o
);

    localparam int MAXC = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t STEP_LAST = cnt_t'(STEP_CYCLES - 1);
    localparam cnt_t DEAD_LAST = cnt_t'(DEAD_CYCLES - 1);
    localparam row_t ROW_LAST  = row_t'(PINS - 1);

    scan_state_e state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    brightness_t pwm_q, pwm_d;
    row_t        row_q, row_d;
    logic        fsync_q, fsync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DEAD;
            cnt_q   <= '0;
            pwm_q   <= '0;
            row_q   <= '0;
            fsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            row_q   <= row_d;
            fsync_q <= fsync_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + cnt_t'(1);
        pwm_d   = pwm_q;
        row_d   = row_q;
        unique case (state_q)
            DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    pwm_d = pwm_q + brightness_t'(1);
                    if (pwm_q == '1) begin
                        state_d = DEAD;
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + row_t'(1);
                    end
                end
            end
        endcase
        // Frame sync marks the final cycle of the last row's DRIVE window.
        fsync_d = (state_d == DRIVE) && (row_d == ROW_LAST) &&
                  (pwm_d == '1) && (cnt_d == STEP_LAST);
    end

    assign row_d_o      = row_d;
    assign pwm_d_o      = pwm_d;
    assign drive_d_o    = (state_d == DRIVE);
    assign frame_sync_o = fsync_q;

endmodule

// File: rtl/charlieplex_scanner.sv
// Charlieplexed 7-pin LED driver with double-buffered brightness store.
// Back buffer is written by the core; front buffer swaps only at frame end.
module charlieplex_scanner
    import charlieplex_pkg::*;
#(
    parameter int STEP_CYCLES = 64,
    parameter int DEAD_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    charlieplex_if.slave    wr,
    output logic            frame_sync,
    output logic [PINS-1:0] charlieplex_oe,
    output logic [PINS-1:0] charlieplex_o
);

    row_t        row_d;
    brightness_t pwm_d;
    logic        drive_d;

    brightness_t [LEDS-1:0] back_q;
    brightness_t [LEDS-1:0] front_q;

    logic            pending_q, pending_d;
    logic [PINS-1:0] oe_q, oe_d;
    logic [PINS-1:0] o_q, o_d;
    logic            wr_fire;

    charlieplex_pwm_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .row_d_o      (row_d),
        .pwm_d_o      (pwm_d),
        .drive_d_o    (drive_d),
        .frame_sync_o (frame_sync)
    );

    assign wr.wr_ready       = !pending_q;
    assign wr.commit_pending = pending_q;
    assign wr_fire           = wr.wr_valid && !pending_q;
    assign charlieplex_oe    = oe_q;
    assign charlieplex_o     = o_q;

    // A commit seen on the sync cycle itself waits for the next frame.
    always_comb begin
        pending_d = pending_q ? !frame_sync : wr.wr_commit;
    end

    always_comb begin
        oe_d = '0;
        o_d  = '0;
        if (drive_d) begin
            for (int p = 0; p < PINS; p++) begin
                if (row_t'(p) == row_d) begin
                    oe_d[p] = 1'b1;
                    o_d[p]  = 1'b1;
                end else begin
                    oe_d[p] = front_q[led_index(row_d, row_t'(p))] > pwm_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back_q    <= '0;
            front_q   <= '0;
            pending_q <= 1'b0;
            oe_q      <= '0;
            o_q       <= '0;
        end else begin
            pending_q <= pending_d;
            oe_q      <= oe_d;
            o_q       <= o_d;
            if (wr_fire && (int'(wr.wr_addr) < LEDS)) begin
                back_q[wr.wr_addr] <= wr.wr_data;
            end
            if (pending_q && frame_sync) begin
                front_q <= back_q;
            end
        end
    end

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Directed bench for charlieplex_scanner with short scan timing.
// Cycle 0 is the first clock period after reset release.
module tb_charlieplex_scanner;
    import charlieplex_pkg::*;

    localparam int STEP  = 2;
    localparam int DEAD  = 3;
    localparam int ROWP  = 35;
    localparam int FRAME = 245;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_sync;
    logic [6:0] oe;
    logic [6:0] o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int front [42];

    charlieplex_if wr ();

    charlieplex_scanner #(
        .STEP_CYCLES (STEP),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr             (wr),
        .frame_sync     (frame_sync),
        .charlieplex_oe (oe),
        .charlieplex_o  (o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_oe(int c);
        int r, t, pwm;
        logic [6:0] v;
        v = '0;
        r = (c % FRAME) / ROWP;
        t = c % ROWP;
        if (t >= DEAD) begin
            pwm  = (t - DEAD) / STEP;
            v[r] = 1'b1;
            for (int p = 0; p < 7; p++)
                if (p != r && front[r*6 + ((p < r) ? p : p - 1)] > pwm)
                    v[p] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [6:0] exp_o(int c);
        logic [6:0] v;
        v = '0;
        if ((c % ROWP) >= DEAD) v[(c % FRAME) / ROWP] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_fs(int c);
        return (c % FRAME) == FRAME - 1;
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        wr.wr_valid  = 1'b0;
        wr.wr_addr   = '0;
        wr.wr_data   = '0;
        wr.wr_commit = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        foreach (front[i]) front[i] = 0;
    endtask

    task automatic write1(int a, int d);
        wr.wr_valid = 1'b1;
        wr.wr_addr  = led_addr_t'(a);
        wr.wr_data  = brightness_t'(d);
        step();
        wr.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (oe !== 7'h00) begin fails++; $display("FAIL reset_oe got=%h exp=00", oe); end
        tests++;
        if (o !== 7'h00) begin fails++; $display("FAIL reset_o got=%h exp=00", o); end
        tests++;
        if (frame_sync !== 1'b0) begin fails++; $display("FAIL reset_fs got=%b exp=0", frame_sync); end
        tests++;
        if (wr.commit_pending !== 1'b0) begin fails++; $display("FAIL reset_pending got=%b exp=0", wr.commit_pending); end
        tests++;
        if (wr.wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", wr.wr_ready); end
    endtask

    task automatic test_idle_scan();
        do_reset();
        while (cyc < 2*FRAME) begin
            tests++;
            if ({frame_sync, oe, o} !== {exp_fs(cyc), exp_oe(cyc), exp_o(cyc)}) begin
                fails++;
                $display("FAIL idle_scan cyc=%0d got fs=%b oe=%b o=%b exp fs=%b oe=%b o=%b",
                         cyc, frame_sync, oe, o, exp_fs(cyc), exp_oe(cyc), exp_o(cyc));
            end
            if (cyc == 2 || cyc == 3 || cyc == 34 || cyc == 35 || cyc == 38) begin
                logic [6:0] want;
                want = (cyc == 2 || cyc == 35) ? 7'b0000000 :
                       (cyc == 38) ? 7'b0000010 : 7'b0000001;
                tests++;
                if (oe !== want) begin
                    fails++;
                    $display("FAIL idle_edge cyc=%0d got=%b exp=%b", cyc, oe, want);
                end
            end
            if (cyc == 244 || cyc == 489) begin
                tests++;
                if (frame_sync !== 1'b1) begin
                    fails++;
                    $display("FAIL idle_fs cyc=%0d got=%b exp=1", cyc, frame_sync);
                end
            end
            step();
        end
    endtask

    task automatic test_commit_row0();
        int lit;
        lit = 0;
        do_reset();
        write1(0, 15);
        wr.wr_commit = 1'b1;
        step();
        wr.wr_commit = 1'b0;
        tests++;
        if ({wr.wr_ready, wr.commit_pending} !== 2'b01) begin
            fails++;
            $display("FAIL c0_pending cyc=%0d got rdy/pend=%b exp=01", cyc, {wr.wr_ready, wr.commit_pending});
        end
        while (cyc < 2*FRAME) begin
            if (cyc == FRAME) begin
                front[0] = 15;
                tests++;
                if ({wr.wr_ready, wr.commit_pending} !== 2'b10) begin
                    fails++;
                    $display("FAIL c0_release got rdy/pend=%b exp=10", {wr.wr_ready, wr.commit_pending});
                end
            end
            if (cyc == FRAME - 1) begin
                tests++;
                if (wr.wr_ready !== 1'b0) begin fails++; $display("FAIL c0_ready_fs got=%b exp=0", wr.wr_ready); end
            end
            tests++;
            if ({frame_sync, oe, o} !== {exp_fs(cyc), exp_oe(cyc), exp_o(cyc)}) begin
                fails++;
                $display("FAIL c0_scan cyc=%0d got oe=%b o=%b fs=%b exp oe=%b", cyc, oe, o, frame_sync, exp_oe(cyc));
            end
            if (cyc >= FRAME && cyc < FRAME + ROWP && oe[1]) lit++;
            step();
        end
        tests++;
        if (lit !== 30) begin fails++; $display("FAIL c0_lit_cycles got=%0d exp=30", lit); end
    endtask

    task automatic test_rows_6_1();
        int lit6, lit1;
        lit6 = 0;
        lit1 = 0;
        do_reset();
        write1(41, 8);
        write1(6, 1);
        wr.wr_commit = 1'b1;
        step();
        wr.wr_commit = 1'b0;
        while (cyc < 2*FRAME) begin
            if (cyc == FRAME) begin
                front[41] = 8;
                front[6]  = 1;
            end
            tests++;
            if ({frame_sync, oe, o} !== {exp_fs(cyc), exp_oe(cyc), exp_o(cyc)}) begin
                fails++;
                $display("FAIL r61_scan cyc=%0d got oe=%b o=%b exp oe=%b", cyc, oe, o, exp_oe(cyc));
            end
            if (cyc >= FRAME + 6*ROWP && oe[5]) lit6++;
            if (cyc >= FRAME + ROWP && cyc < FRAME + 2*ROWP && oe[0]) lit1++;
            step();
        end
        tests++;
        if (lit6 !== 16) begin fails++; $display("FAIL r6_lit got=%0d exp=16", lit6); end
        tests++;
        if (lit1 !== 2) begin fails++; $display("FAIL r1_lit got=%0d exp=2", lit1); end
    endtask

    task automatic test_back_to_back();
        int lit;
        lit = 0;
        do_reset();
        wr.wr_commit = 1'b1;
        step();
        wr.wr_commit = 1'b0;
        wr.wr_valid  = 1'b1;
        wr.wr_addr   = led_addr_t'(1);
        wr.wr_data   = brightness_t'(4);
        while (!wr.wr_ready && cyc < 400) begin
            if (cyc == 100) wr.wr_commit = 1'b1;
            else wr.wr_commit = 1'b0;
            step();
        end
        tests++;
        if (cyc !== FRAME) begin
            fails++;
            $display("FAIL b2b_ready_cycle got=%0d exp=%0d", cyc, FRAME);
        end
        step();
        wr.wr_valid  = 1'b0;
        wr.wr_commit = 1'b1;
        step();
        wr.wr_commit = 1'b0;
        while (cyc < 3*FRAME) begin
            if (cyc == 2*FRAME) front[1] = 4;
            tests++;
            if ({frame_sync, oe, o} !== {exp_fs(cyc), exp_oe(cyc), exp_o(cyc)}) begin
                fails++;
                $display("FAIL b2b_scan cyc=%0d got oe=%b o=%b exp oe=%b", cyc, oe, o, exp_oe(cyc));
            end
            if (cyc >= 2*FRAME && cyc < 2*FRAME + ROWP && oe[2]) lit++;
            step();
        end
        tests++;
        if (lit !== 8) begin fails++; $display("FAIL b2b_lit got=%0d exp=8", lit); end
    endtask

    task automatic test_oob_and_sync_commit();
        do_reset();
        write1(42, 15);
        write1(20, 15);
        while (cyc < 3*FRAME) begin
            if (cyc == 2*FRAME) begin
                front[20] = 15;
                tests++;
                if (wr.commit_pending !== 1'b0) begin fails++; $display("FAIL fsc_cleared got=%b exp=0", wr.commit_pending); end
            end
            tests++;
            if ({frame_sync, oe, o} !== {exp_fs(cyc), exp_oe(cyc), exp_o(cyc)}) begin
                fails++;
                $display("FAIL oob_scan cyc=%0d got oe=%b o=%b exp oe=%b", cyc, oe, o, exp_oe(cyc));
            end
            if (cyc == FRAME - 1) begin
                wr.wr_commit = 1'b1;
                step();
                wr.wr_commit = 1'b0;
                tests++;
                if (wr.commit_pending !== 1'b1) begin fails++; $display("FAIL fsc_latched got=%b exp=1", wr.commit_pending); end
            end else begin
                step();
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        write1(0, 15);
        wr.wr_commit = 1'b1;
        step();
        wr.wr_commit = 1'b0;
        step(258);
        tests++;
        if (oe !== 7'b0000011) begin fails++; $display("FAIL ar_lit got=%b exp=0000011", oe); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({oe, o} !== 14'h0) begin fails++; $display("FAIL ar_async got oe=%b o=%b exp 0", oe, o); end
        do_reset();
        wr.wr_commit = 1'b1;
        step();
        wr.wr_commit = 1'b0;
        while (cyc < 2*FRAME) begin
            tests++;
            if ({frame_sync, oe, o} !== {exp_fs(cyc), exp_oe(cyc), exp_o(cyc)}) begin
                fails++;
                $display("FAIL ar_scan cyc=%0d got oe=%b o=%b exp oe=%b", cyc, oe, o, exp_oe(cyc));
            end
            step();
        end
    endtask

    initial begin
        wr.wr_valid  = 1'b0;
        wr.wr_addr   = '0;
        wr.wr_data   = '0;
        wr.wr_commit = 1'b0;
        #12;
        test_reset();
        test_idle_scan();
        test_commit_row0();
        test_rows_6_1();
        test_back_to_back();
        test_oob_and_sync_commit();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
